boot_rom_reader: RTL
====================

# boot_rom_reader

Request/response front end for the 128-bit boot ROM: accepts tagged physical-address line reads from the fetch/memory side over a valid/ready handshake, decodes them against the ROM window, and drives the ROM's 9-bit line address. It samples the combinational 128-bit line and returns it with its tag through a 3-entry response queue. The block sits between the fetch unit's uncached port and the boot ROM, so the ROM stays purely combinational. The block rejects writes and out-of-window addresses with an error response; it never forwards them to the ROM.

## Interface
- ADDR_W, 56: physical byte-address width
- BASE, 56'h0: byte address of ROM line 0; must be 16-byte aligned
- ROM_LINES, 10: number of populated 128-bit lines (1..512)
- TAG_W, 4: request/response tag width

- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  discard all in-flight and queued work
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_addr  in  ADDR_W  byte address; bits [3:0] ignored
- req_write  in  1  write attempt; always errors
- req_tag  in  TAG_W  returned unchanged on the response
- rom_addr  out  9  line index to the boot ROM
- rom_data  in  128  combinational ROM line for rom_addr
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  128  line data; 0 when rsp_err
- rsp_tag  out  TAG_W  tag of the request
- rsp_err  out  1  write, or address outside [BASE, BASE+16*ROM_LINES)

## Operation
- Stage S1 (issue register): holds s1_valid, s1_tag and s1_err, plus rom_addr as a registered line index.
- Queue Q: 3-entry FIFO of {data, tag, err}, with count 0..3, a read pointer and a write pointer that wrap mod 3.
- req_ready = !flush && (count + s1_valid) < 3. It depends only on state and flush and has no combinational path from rsp_ready.
- Accept (req_valid && req_ready):
  - off = req_addr - BASE, computed at ADDR_W bits.
  - err = req_write || req_addr < BASE || off[ADDR_W-1:4] >= ROM_LINES.
  - rom_addr <= err ? rom_addr : off[12:4]. An error holds the previous index, so the ROM never sees an out-of-window index.
  - s1_valid <= 1; s1_tag and s1_err are loaded.
- No accept: s1_valid <= 0, and rom_addr holds.
- S1 valid: Q writes {s1_err ? 0 : rom_data, s1_tag, s1_err} at the next edge. Space is guaranteed by the req_ready rule.
- Head of Q drives rsp_*; rsp_valid = (count != 0). A pop happens on rsp_valid && rsp_ready.
- A push and a pop in the same cycle leave count unchanged and advance both pointers.
- Responses return in request order; the block neither reorders nor coalesces them.
- flush (sampled on the edge):
  - s1_valid <= 0; count, read pointer and write pointer <= 0.
  - No request is accepted in a flush cycle.
  - A response handshaking in the flush cycle still counts as delivered.
- Reset values:
  - req_ready = 1 (after reset release).
  - rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_err = 0.
  - rom_addr = 0; s1_valid = 0; count = 0; pointers = 0.
- Reset asserted mid-operation: all state clears immediately. Pending requests are lost and produce no response.

## Timing
- Latency: a request accepted at edge E0 drives rom_addr during cycle E0..E1. The data is captured into Q at E1, and rsp_valid is high after E1, 2 edges after acceptance.
- Throughput: 1 line/cycle sustained while rsp_ready is held high (steady state count=1, s1_valid=1).
- Backpressure: with rsp_ready low, at most 3 requests are accepted, then req_ready drops.
  - After the first pop, req_ready rises in the cycle following that edge.
- rom_addr is stable for a full cycle before sampling, so the combinational ROM path is clk-to-Q plus ROM decode.
- Error responses take the same 2-edge latency as good reads; they stay ordered with them.

## Test plan
- Reset, then read BASE+0x00, BASE+0x10 and BASE+0x90 with tags 1, 2, 3 and rsp_ready=1:
  - Responses arrive on 3 consecutive cycles, 2 edges after each accept.
  - rsp_data equals ROM lines 0, 1 and 9; tags are 1, 2, 3; rsp_err=0.
- req_addr = BASE+0x17: returns line 1, because the low nibble is ignored.
- Error cases:
  - req_addr = BASE+0xA0 (line 10 with ROM_LINES=10) returns err=1, data=0.
  - req_write=1 at BASE returns err=1, data=0.
  - In both cases rom_addr keeps its prior value.
- Backpressure:
  - Hold rsp_ready=0 and stream 5 requests: exactly 3 are accepted, then req_ready=0.
  - Raise rsp_ready: responses drain in order, and requests 4 and 5 are then accepted and returned.
- Assert flush for one cycle with 2 queued and 1 in S1: rsp_valid=0 the next cycle, and no stale responses appear.
  - A new request after the flush gets its response 2 edges later.
- Drop reset_n asynchronously mid-stream: rsp_valid, rom_addr and count are 0 immediately.
  - After release, req_ready=1 and a read of BASE returns line 0.

Source files
------------

// File: rtl/boot_rom_reader.sv
// Request/response front end for the 128-bit boot ROM: decodes tagged line
// reads against the ROM window, drives a registered line index, and returns
// sampled lines through a 3-entry in-order response queue.
module boot_rom_reader #(
  parameter int unsigned          ADDR_W    = 56,
  parameter logic [ADDR_W-1:0]    BASE      = '0,
  parameter int unsigned          ROM_LINES = 10,
  parameter int unsigned          TAG_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [8:0]        rom_addr,
  input  logic [127:0]      rom_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [127:0]      rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err
);

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned IDX_W   = 9;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned OCC_W   = 3;
  // Line offset plus one borrow bit from the BASE subtraction.
  localparam int unsigned DIFF_W  = ADDR_W - 3;
  localparam int unsigned LINE_HI = ADDR_W - 4;

  logic [DIFF_W-1:0]  diff_line;
  logic [LINE_HI-1:0] line_off;
  logic               addr_below;
  logic               addr_above;
  logic               req_err;
  logic [OCC_W-1:0]   occupancy;
  logic               accept;
  logic               push;
  logic               pop;

  logic               s1_valid;
  logic [TAG_W-1:0]   s1_tag;
  logic               s1_err;

  logic [LINE_W-1:0]  q_data [DEPTH];
  logic [TAG_W-1:0]   q_tag  [DEPTH];
  logic               q_err  [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // Address decode: borrow bit flags addresses below BASE.
  assign diff_line  = DIFF_W'(({1'b0, req_addr} - {1'b0, BASE}) >> 4);
  assign addr_below = diff_line[DIFF_W-1];
  assign line_off   = diff_line[LINE_HI-1:0];
  assign addr_above = line_off >= LINE_HI'(ROM_LINES);
  assign req_err    = req_write | addr_below | addr_above;

  // Everything in flight (issue stage plus queue) must fit in the queue.
  assign occupancy = OCC_W'(count) + OCC_W'(s1_valid);
  assign req_ready = !flush && (occupancy < OCC_W'(DEPTH));
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (count != '0);
  assign rsp_data  = q_data[rd_ptr];
  assign rsp_tag   = q_tag[rd_ptr];
  assign rsp_err   = q_err[rd_ptr];

  assign push = s1_valid && !flush;
  assign pop  = rsp_valid && rsp_ready;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Issue stage; errors keep the previous ROM index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
      rom_addr <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_tag <= req_tag;
        s1_err <= req_err;
        if (!req_err) begin
          rom_addr <= line_off[IDX_W-1:0];
        end
      end
    end
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + CNT_W'(1));
        2'b01:   count <= CNT_W'(count - CNT_W'(1));
        default: count <= count;
      endcase
    end
  end

  // Queue storage; error entries carry zero data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= '0;
        q_tag[i]  <= '0;
        q_err[i]  <= 1'b0;
      end
    end else if (push) begin
      q_data[wr_ptr] <= s1_err ? '0 : rom_data;
      q_tag[wr_ptr]  <= s1_tag;
      q_err[wr_ptr]  <= s1_err;
    end
  end

endmodule
